// File: rtl/codec_ctrl_pkg.sv
// codec_ctrl_pkg: engine op codes, sequencer states and init-table entry type shared by the codec control slice
package codec_ctrl_pkg;
  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ = 2'd2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_GAP, S_RSTART, S_STOP, S_NEXT} state_t;
  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } init_entry_t;
endpackage

// File: rtl/codec_i2c_ctrl_if.sv
// codec_i2c_ctrl_if: host request/response bundle (req/req_we/req_reg/req_wdata in, busy/done/err/rdata/init_done out)
interface codec_i2c_ctrl_if;
  logic req, req_we, busy, done, err, init_done;
  logic [7:0] req_reg, req_wdata, rdata;
  modport master (output req, req_we, req_reg, req_wdata, input busy, done, err, rdata, init_done);
  modport slave (input req, req_we, req_reg, req_wdata, output busy, done, err, rdata, init_done);
endinterface

// File: rtl/codec_init_rom.sv
// codec_init_rom: boot-time codec register table; idx_i selects entry_o {reg_addr, data}
module codec_init_rom
  import codec_ctrl_pkg::*;
(
  input  logic [7:0]  idx_i,
  output init_entry_t entry_o
);
  always_comb
    case (idx_i)
      8'd0: entry_o = '{8'h1E, 8'h00};
      8'd1: entry_o = '{8'h0C, 8'h10};
      8'd2: entry_o = '{8'h00, 8'h17};
      8'd3: entry_o = '{8'h02, 8'h17};
      8'd4: entry_o = '{8'h04, 8'h79};
      8'd5: entry_o = '{8'h06, 8'h79};
      8'd6: entry_o = '{8'h08, 8'h12};
      8'd7: entry_o = '{8'h0A, 8'h06};
      8'd8: entry_o = '{8'h0E, 8'h02};
      8'd9: entry_o = '{8'h12, 8'h01};
      default: entry_o = '0;
    endcase
endmodule

// File: rtl/codec_i2c_ctrl.sv
// codec_i2c_ctrl: frames START/addr/reg/data/STOP around i2c_engine byte ops, replays the init table, serves host register reads/writes
// ports: clk/rst; host = slave side of codec_i2c_ctrl_if; eng_op/eng_wdata to engine, eng_rdata/eng_ack from engine;
//        bus_ovr/scl_ovr/sda_ovr to the pad mux (override owns the lines during START/RSTART/STOP and idle)
module codec_i2c_ctrl
  import codec_ctrl_pkg::*;
#(
  parameter logic [15:0] C_CLK_DIVISOR = 16'd2,
  parameter logic [6:0]  C_DEV_ADDR    = 7'h1A,
  parameter logic [7:0]  C_INIT_LEN    = 8'd10,
  parameter logic [3:0]  C_MAX_RETRY   = 4'd3
) (
  input  logic                    clk,
  input  logic                    rst,
  codec_i2c_ctrl_if.slave         host,
  output logic [1:0]              eng_op,
  output logic [7:0]              eng_wdata,
  input  logic [7:0]              eng_rdata,
  input  logic                    eng_ack,
  output logic                    bus_ovr,
  output logic                    scl_ovr,
  output logic                    sda_ovr
);
  localparam logic [15:0] H = C_CLK_DIVISOR >> 1;
  localparam logic [15:0] PH_LAST = 16'd3 * H - 16'd1;
  localparam logic [15:0] WIN_LAST = 16'd9 * C_CLK_DIVISOR - 16'd1;
  state_t state_q, state_d;
  logic [15:0] ph_q, ph_d, win_q, win_d;
  logic [2:0] bi_q, bi_d;
  logic [3:0] rt_q, rt_d;
  logic [7:0] idx_q, idx_d, reg_q, reg_d, dat_q, dat_d, rdata_q, rdata_d, tx_d;
  logic we_q, we_d, host_q, host_d, nack_q, nack_d, ack_q, ack_d, busy_q, busy_d;
  logic done_q, done_d, err_q, err_d, init_done_q, init_done_d, launch, rd_q, rd_d, p0, p1;
  init_entry_t ent;

  codec_init_rom u_rom (.idx_i(idx_q), .entry_o(ent));

  assign rd_q = !we_q && bi_q == 3'd3;
  assign host.busy = busy_q;
  assign host.done = done_q;
  assign host.err = err_q;
  assign host.rdata = rdata_q;
  assign host.init_done = init_done_q;

  always_comb begin
    state_d = state_q;
    ph_d = ph_q + 16'd1;
    win_d = win_q + 16'd1;
    bi_d = bi_q;
    rt_d = rt_q;
    idx_d = idx_q;
    we_d = we_q;
    host_d = host_q;
    nack_d = nack_q;
    ack_d = ack_q | eng_ack;
    reg_d = reg_q;
    dat_d = dat_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    rdata_d = rdata_q;
    init_done_d = init_done_q;
    launch = 1'b0;
    case (state_q)
      S_IDLE:
        if (!init_done_q && idx_q == C_INIT_LEN) begin
          init_done_d = 1'b1;
          busy_d = 1'b0;
        end else if (!init_done_q) begin
          launch = 1'b1;
          we_d = 1'b1;
          host_d = 1'b0;
          reg_d = ent.reg_addr;
          dat_d = ent.data;
        end else if (!busy_q && host.req) begin
          launch = 1'b1;
          we_d = host.req_we;
          host_d = 1'b1;
          reg_d = host.req_reg;
          dat_d = host.req_wdata;
          busy_d = 1'b1;
          err_d = 1'b0;
        end
      S_START, S_RSTART:
        if (ph_q == PH_LAST) begin
          state_d = S_BYTE;
          win_d = '0;
          ack_d = 1'b0;
        end
      S_BYTE:
        if (win_q == WIN_LAST) begin
          rdata_d = rd_q ? eng_rdata : rdata_q;
          if (!rd_q && !ack_d) begin
            state_d = S_STOP;
            ph_d = '0;
            nack_d = 1'b1;
          end else begin
            state_d = S_GAP;
            bi_d = bi_q + 3'd1;
          end
        end
      S_GAP: begin
        ph_d = '0;
        win_d = '0;
        ack_d = 1'b0;
        state_d = bi_q == (we_q ? 3'd3 : 3'd4) ? S_STOP : (!we_q && bi_q == 3'd2) ? S_RSTART : S_BYTE;
      end
      S_STOP:
        if (ph_q == PH_LAST) state_d = S_NEXT;
      S_NEXT:
        if (nack_q && rt_q != C_MAX_RETRY) launch = 1'b1;
        else begin
          state_d = S_IDLE;
          err_d = err_q | nack_q;
          done_d = host_q;
          busy_d = busy_q & !host_q;
          idx_d = host_q ? idx_q : idx_q + 8'd1;
        end
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      state_d = S_START;
      ph_d = '0;
      bi_d = '0;
      nack_d = 1'b0;
      rt_d = state_q == S_NEXT ? rt_q + 4'd1 : 4'd0;
    end
    rd_d = !we_d && bi_d == 3'd3;
    tx_d = bi_d == 3'd0 ? {C_DEV_ADDR, 1'b0} : bi_d == 3'd1 ? reg_d : bi_d != 3'd2 ? 8'hFF : we_d ? dat_d : {C_DEV_ADDR, 1'b1};
    p0 = ph_d < H;
    p1 = ph_d < 16'd2 * H;
  end

  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_IDLE;
      ph_q <= '0;
      win_q <= '0;
      bi_q <= '0;
      rt_q <= '0;
      idx_q <= '0;
      we_q <= 1'b0;
      host_q <= 1'b0;
      nack_q <= 1'b0;
      ack_q <= 1'b0;
      reg_q <= '0;
      dat_q <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
      init_done_q <= 1'b0;
      eng_op <= OP_IDLE;
      eng_wdata <= '0;
      bus_ovr <= 1'b1;
      scl_ovr <= 1'b1;
      sda_ovr <= 1'b1;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      win_q <= win_d;
      bi_q <= bi_d;
      rt_q <= rt_d;
      idx_q <= idx_d;
      we_q <= we_d;
      host_q <= host_d;
      nack_q <= nack_d;
      ack_q <= ack_d;
      reg_q <= reg_d;
      dat_q <= dat_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      init_done_q <= init_done_d;
      eng_op <= state_d == S_BYTE ? (rd_d ? OP_READ : OP_WRITE) : OP_IDLE;
      eng_wdata <= state_d == S_IDLE ? eng_wdata : tx_d;
      bus_ovr <= !(state_d inside {S_BYTE, S_GAP});
      {scl_ovr, sda_ovr} <= (state_d == S_START || state_d == S_RSTART) ? {p1, p0} : state_d == S_STOP ? {!p0, !p1} : 2'b11;
    end
endmodule

// File: tb/tb_codec_i2c_ctrl.sv
// tb_codec_i2c_ctrl: directed bench with a byte-level engine model for codec_i2c_ctrl
module tb_codec_i2c_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] eng_op;
  logic [7:0] eng_wdata, eng_rdata = 8'h00;
  logic eng_ack = 1'b0, bus_ovr, scl_ovr, sda_ovr, nack_addr = 1'b0;
  logic [1:0] ll = 2'b11;
  int vecs = 0, miss = 0, starts = 0, stops = 0, lat, n, np;
  logic [9:0] blog[$], exp_q[$];
  logic [1:0] lq[$];

  codec_i2c_ctrl_if ifc ();

  codec_i2c_ctrl #(.C_CLK_DIVISOR(16'd2), .C_DEV_ADDR(7'h1A), .C_INIT_LEN(8'd2), .C_MAX_RETRY(4'd3)) dut (
    .clk(clk), .rst(rst), .host(ifc), .eng_op(eng_op), .eng_wdata(eng_wdata), .eng_rdata(eng_rdata),
    .eng_ack(eng_ack), .bus_ovr(bus_ovr), .scl_ovr(scl_ovr), .sda_ovr(sda_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int len);
    chk({tag, "_nbytes"}, blog.size(), len);
    for (int i = 0; i < exp_q.size() && i < blog.size(); i++) chk($sformatf("%s_byte%0d", tag, i), blog[i], exp_q[i]);
  endtask

  task automatic clear();
    blog.delete();
    lq.delete();
    ll = 2'b11;
    starts = 0;
    stops = 0;
  endtask

  task automatic go(input logic we, input logic [7:0] r, input logic [7:0] d);
    ifc.req_we = we;
    ifc.req_reg = r;
    ifc.req_wdata = d;
    ifc.req = 1'b1;
    @(negedge clk);
    ifc.req = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ifc.done !== 1'b1 && cyc < maxc);
    chk("done_seen", ifc.done, 1);
  endtask

  task automatic wait_init(input int maxc);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (ifc.init_done !== 1'b1 && c < maxc);
    chk("init_done_seen", ifc.init_done, 1);
  endtask

  // engine/slave model: logs each byte window, checks its length, ACKs mid-window, watches START/STOP on the override
  initial begin
    logic [1:0] pop = 2'd0;
    logic [2:0] pl = 3'b111;
    int w = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        w = 0;
        pop = 2'd0;
        pl = 3'b111;
        eng_ack = 1'b0;
      end else begin
        if (eng_op != 2'd0) begin
          if (pop == 2'd0) blog.push_back({eng_op, eng_wdata});
          w = (pop == 2'd0) ? 1 : w + 1;
        end else if (pop != 2'd0) chk("win_len", w, 18);
        eng_ack = eng_op == 2'd1 && w == 8 && !(nack_addr && eng_wdata[7:1] == 7'h1A);
        if (pl == 3'b111 && {bus_ovr, scl_ovr, sda_ovr} == 3'b110) starts++;
        if (pl == 3'b110 && {bus_ovr, scl_ovr, sda_ovr} == 3'b111) stops++;
        if (bus_ovr && {scl_ovr, sda_ovr} != ll) begin
          ll = {scl_ovr, sda_ovr};
          lq.push_back(ll);
        end
        pop = eng_op;
        pl = {bus_ovr, scl_ovr, sda_ovr};
      end
    end
  end

  initial begin
    ifc.req = 1'b0;
    ifc.req_we = 1'b0;
    ifc.req_reg = 8'h00;
    ifc.req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", ifc.busy, 1);
    chk("rst_done", ifc.done, 0);
    chk("rst_err", ifc.err, 0);
    chk("rst_rdata", ifc.rdata, 0);
    chk("rst_init_done", ifc.init_done, 0);
    chk("rst_eng_op", eng_op, 0);
    chk("rst_eng_wdata", eng_wdata, 0);
    chk("rst_bus_ovr", bus_ovr, 1);
    chk("rst_scl", scl_ovr, 1);
    chk("rst_sda", sda_ovr, 1);
    clear();
    rst = 1'b0;
    wait_init(1000);
    exp_q = {10'h134, 10'h11E, 10'h100, 10'h134, 10'h10C, 10'h110};
    chk_log("init", 6);
    chk("init_starts", starts, 2);
    chk("init_stops", stops, 2);
    chk("init_err", ifc.err, 0);
    chk("init_busy", ifc.busy, 0);

    clear();
    go(1'b1, 8'h07, 8'h4A);
    chk("wr_busy", ifc.busy, 1);
    wait_done(400, lat);
    chk("wr_latency_window", 32'(lat + 1 >= 64 && lat + 1 <= 68), 1);
    chk("wr_busy_at_done", ifc.busy, 0);
    chk("wr_err", ifc.err, 0);
    exp_q = {10'h134, 10'h107, 10'h14A};
    chk_log("wr", 3);
    chk("wr_starts", starts, 1);
    chk("wr_stops", stops, 1);
    chk("wr_line_steps", lq.size(), 4);
    chk("wr_line_shape", {lq[0], lq[1], lq[2], lq[3]}, 8'b10_00_10_11);
    @(negedge clk);
    chk("wr_done_pulse", ifc.done, 0);

    clear();
    eng_rdata = 8'hA5;
    go(1'b0, 8'h05, 8'h00);
    wait_done(400, lat);
    chk("rd_rdata", ifc.rdata, 8'hA5);
    exp_q = {10'h134, 10'h105, 10'h135};
    chk_log("rd", 4);
    chk("rd_last_op", blog[3][9:8], 2);
    chk("rd_starts", starts, 2);
    chk("rd_stops", stops, 1);
    @(negedge clk);
    chk("rd_done_pulse", ifc.done, 0);

    clear();
    nack_addr = 1'b1;
    go(1'b1, 8'h10, 8'h55);
    wait_done(600, lat);
    chk("nack_err", ifc.err, 1);
    exp_q = {10'h134, 10'h134, 10'h134, 10'h134};
    chk_log("nack", 4);
    chk("nack_starts", starts, 4);
    chk("nack_stops", stops, 4);
    nack_addr = 1'b0;
    @(negedge clk);
    chk("nack_err_sticky", ifc.err, 1);

    clear();
    go(1'b1, 8'h20, 8'h11);
    chk("busy_err_cleared", ifc.err, 0);
    repeat (8) @(negedge clk);
    chk("busy_mid", ifc.busy, 1);
    go(1'b1, 8'h21, 8'h99);
    wait_done(400, lat);
    exp_q = {10'h134, 10'h120, 10'h111};
    chk_log("busy_ignored", 3);
    chk("busy_starts", starts, 1);
    @(negedge clk);
    clear();
    go(1'b1, 8'h22, 8'h33);
    wait_done(400, lat);
    exp_q = {10'h134, 10'h122, 10'h133};
    chk_log("after_busy", 3);

    @(negedge clk);
    clear();
    go(1'b1, 8'h30, 8'h66);
    n = 0;
    while (blog.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_data", 32'(blog.size() >= 3), 1);
    repeat (5) @(negedge clk);
    np = stops;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_op", eng_op, 0);
    chk("mid_rst_ovr", bus_ovr, 1);
    chk("mid_rst_scl", scl_ovr, 1);
    chk("mid_rst_sda", sda_ovr, 1);
    chk("mid_rst_no_stop", stops, np);
    chk("mid_rst_init_done", ifc.init_done, 0);
    @(negedge clk);
    clear();
    rst = 1'b0;
    wait_init(1000);
    exp_q = {10'h134, 10'h11E, 10'h100, 10'h134, 10'h10C, 10'h110};
    chk_log("reinit", 6);
    chk("reinit_err", ifc.err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
